// File: rtl/eth_tx_framer.sv
// Ethernet TX framer: prepends a 14-byte MAC header to a 64-bit
// AXI-Stream payload and re-aligns the bytes toward the MAC.
module eth_tx_framer #(
  parameter int          inwidth = 64,
  parameter logic [47:0] dest    = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] source  = 48'hFFFF_FFFF_FFFF,
  parameter logic [15:0] etype   = 16'h0800
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [inwidth-1:0]     s_tdata,
  input  logic [inwidth/8-1:0]   s_tkeep,
  input  logic                   s_tvalid,
  input  logic                   s_tlast,
  output logic                   s_tready,
  output logic [inwidth-1:0]     m_tdata,
  output logic [inwidth/8-1:0]   m_tkeep,
  output logic                   m_tvalid,
  output logic                   m_tlast,
  input  logic                   m_tready
);

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    BODY,
    TAIL
  } state_t;

  state_t      r_state;
  state_t      w_state_nx;
  logic [63:0] r_tdata;
  logic [63:0] w_tdata_nx;
  logic [7:0]  r_tkeep;
  logic [7:0]  w_tkeep_nx;
  logic        r_tlast;
  logic        w_tlast_nx;
  logic        r_tvalid;
  logic        w_tvalid_nx;
  logic [47:0] r_res;
  logic [47:0] w_res_nx;
  logic [5:0]  r_rkeep;
  logic [5:0]  w_rkeep_nx;
  logic        w_slot_free;
  logic        w_take;
  logic [15:0] w_head;

  assign w_slot_free = !r_tvalid || m_tready;
  assign s_tready    = w_slot_free &&
                       (r_state == HDR || r_state == BODY);
  assign w_take      = s_tvalid && s_tready;
  assign w_head      = s_tdata[63:48];

  assign m_tdata  = r_tdata;
  assign m_tkeep  = r_tkeep;
  assign m_tlast  = r_tlast;
  assign m_tvalid = r_tvalid;

  always_comb begin
    w_state_nx  = r_state;
    w_tdata_nx  = r_tdata;
    w_tkeep_nx  = r_tkeep;
    w_tlast_nx  = r_tlast;
    w_tvalid_nx = r_tvalid && !m_tready;
    w_res_nx    = r_res;
    w_rkeep_nx  = r_rkeep;
    unique case (r_state)
      IDLE: begin
        // Header goes out before the first payload beat is consumed
        if (s_tvalid && w_slot_free) begin
          w_tdata_nx  = {dest, source[47:32]};
          w_tkeep_nx  = 8'hFF;
          w_tlast_nx  = 1'b0;
          w_tvalid_nx = 1'b1;
          w_state_nx  = HDR;
        end
      end
      HDR, BODY: begin
        if (w_take) begin
          if (r_state == HDR) begin
            w_tdata_nx = {source[31:0], etype, w_head};
            w_tkeep_nx = {6'h3F, s_tkeep[7:6]};
          end else begin
            w_tdata_nx = {r_res, w_head};
            w_tkeep_nx = {r_rkeep, s_tkeep[7:6]};
          end
          w_tvalid_nx = 1'b1;
          w_res_nx    = s_tdata[47:0];
          w_rkeep_nx  = s_tkeep[5:0];
          w_tlast_nx  = 1'b0;
          w_state_nx  = BODY;
          if (s_tlast) begin
            if (s_tkeep[5:0] == 6'h00) begin
              w_tlast_nx = 1'b1;
              w_state_nx = IDLE;
            end else begin
              w_state_nx = TAIL;
            end
          end
        end
      end
      TAIL: begin
        if (w_slot_free) begin
          w_tdata_nx  = {r_res, 16'h0000};
          w_tkeep_nx  = {r_rkeep, 2'b00};
          w_tlast_nx  = 1'b1;
          w_tvalid_nx = 1'b1;
          w_state_nx  = IDLE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_tdata  <= '0;
      r_tkeep  <= '0;
      r_tlast  <= 1'b0;
      r_tvalid <= 1'b0;
      r_res    <= '0;
      r_rkeep  <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_tdata  <= w_tdata_nx;
      r_tkeep  <= w_tkeep_nx;
      r_tlast  <= w_tlast_nx;
      r_tvalid <= w_tvalid_nx;
      r_res    <= w_res_nx;
      r_rkeep  <= w_rkeep_nx;
    end
  end

endmodule
